// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ctrl
// Brief    : Pointer, occupancy and status-flag controller for a synchronous
//            first-word-fall-through FIFO built around an external memory core.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr_err,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] c_PTR_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] c_AF_THRESH = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] c_AE_THRESH = (ADDR_WIDTH+1)'(AE_THRESH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0] r_wr_ptr;
  logic [ADDR_WIDTH:0] r_rd_ptr;
  logic                r_overflow;
  logic                r_underflow;

  logic [ADDR_WIDTH:0] w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_pop_ok;
  logic                w_push_ok;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                   (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

  // A pop on a full FIFO frees the slot the same cycle; an empty FIFO has no
  // bypass, so a pop there is refused even if a push arrives alongside it.
  assign w_pop_ok  = pop & ~w_empty;
  assign w_push_ok = push & (~w_full | w_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  // Sticky error flags; a new error event takes priority over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (push && !w_push_ok) r_overflow <= 1'b1;
      else if (clr_err)       r_overflow <= 1'b0;
      if (pop && !w_pop_ok)   r_underflow <= 1'b1;
      else if (clr_err)       r_underflow <= 1'b0;
    end
  end

  assign wr_en        = w_push_ok;
  assign rd_en        = w_pop_ok;
  assign wr_ptr       = r_wr_ptr[ADDR_WIDTH-1:0];
  assign rd_ptr       = r_rd_ptr[ADDR_WIDTH-1:0];
  assign count        = w_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_count >= c_AF_THRESH);
  assign almost_empty = (w_count <= c_AE_THRESH);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ctrl
// Brief    : Self-checking bench for fifo_ctrl against a queue-based FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl;

  localparam int c_AW    = 4;
  localparam int c_DEPTH = 16;
  localparam int c_AF    = 14;
  localparam int c_AE    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             clr_err = 1'b0;
  logic             wr_en, rd_en;
  logic [c_AW-1:0]  wr_ptr, rd_ptr;
  logic [c_AW:0]    count;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;
  logic [7:0]       wdata = 8'h00;

  int tests = 0;
  int fails = 0;

  // Reference state: occupancy, addresses and stored data as plain values.
  logic [7:0] m_q[$];
  int         m_wa = 0;
  int         m_ra = 0;
  bit         m_ov = 0;
  bit         m_uf = 0;

  // Behavioural memory core addressed by the DUT pointers.
  logic [7:0] mem [c_DEPTH];

  fifo_ctrl #(.ADDR_WIDTH(c_AW), .AF_THRESH(c_AF), .AE_THRESH(c_AE)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .clr_err(clr_err),
    .wr_en(wr_en), .rd_en(rd_en), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) mem[wr_ptr] <= wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state();
    int n;
    n = m_q.size();
    chk("count", 32'(count), n);
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == c_DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= c_AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= c_AE));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("wr_ptr", 32'(wr_ptr), m_wa);
    chk("rd_ptr", 32'(rd_ptr), m_ra);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wa = 0; m_ra = 0; m_ov = 0; m_uf = 0;
  endtask

  // One clock cycle: drive at negedge, check just after, model follows the edge.
  task automatic step(input bit p, input bit q, input bit c, input logic [7:0] d);
    bit pop_ok, push_ok;
    @(negedge clk);
    push = p; pop = q; clr_err = c; wdata = d;
    #1;
    pop_ok  = q && (m_q.size() > 0);
    push_ok = p && ((m_q.size() < c_DEPTH) || pop_ok);
    chk_state();
    chk("wr_en", 32'(wr_en), 32'(push_ok));
    chk("rd_en", 32'(rd_en), 32'(pop_ok));
    if (pop_ok) chk("rd_data", 32'(mem[rd_ptr]), 32'(m_q[0]));
    if (pop_ok) begin
      void'(m_q.pop_front());
      m_ra = (m_ra + 1) % c_DEPTH;
    end
    if (push_ok) begin
      m_q.push_back(d);
      m_wa = (m_wa + 1) % c_DEPTH;
    end
    if (p && !push_ok) m_ov = 1; else if (c) m_ov = 0;
    if (q && !pop_ok)  m_uf = 1; else if (c) m_uf = 0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    push = 0; pop = 0; clr_err = 0;
    #1 rst = 1'b1;
    model_reset();
    #1 chk_state();
    #1 rst = 1'b0;
  endtask

  initial begin
    int pushed;
    bit p, q;
    #12 rst = 1'b0;
    // Reset from a dirty state, checked before any clock edge.
    step(1, 0, 0, 8'h11);
    step(1, 0, 0, 8'h12);
    step(0, 1, 0, 8'h00);
    async_reset();

    // Fill, overflow, simultaneous push/pop while full.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'(8'h40 + i));
    step(1, 0, 0, 8'hEE);
    step(1, 1, 0, 8'h50);
    step(0, 0, 0, 8'h00);

    // Drain, underflow, clear.
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);

    // Simultaneous at count 5, then at empty.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'h60 + i));
    step(1, 1, 0, 8'h65);
    step(0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00);
    step(1, 1, 0, 8'h70);
    step(0, 0, 1, 8'h00);
    step(0, 1, 0, 8'h00);

    // Ordered data across several pointer wraps, occupancy held around 3..9.
    pushed = 0;
    while (pushed < 40 || m_q.size() > 0) begin
      p = (pushed < 40) && (m_q.size() < 9) && ((m_q.size() < 3) || ($urandom_range(0, 1) == 1));
      q = (m_q.size() > 3 || pushed >= 40) && (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
      step(p, q, 0, 8'(pushed));
      if (p) pushed++;
    end

    // Unconstrained random traffic including errors and clears.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), 8'($urandom));

    // Reset mid-stream at count 7, then a push must land at address 0.
    async_reset();
    for (int i = 0; i < 7; i++) step(1, 0, 0, 8'(8'hA0 + i));
    async_reset();
    step(1, 0, 0, 8'hC3);
    step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
